binary_to_bcd_seq: RTL

Parametrised, iterative (shift-add-3) binary-to-BCD converter for the numeric display path. It generalises the fixed 36-bit/9-digit converter in width and digit count, and adds:
- a start/busy/done handshake
- an optional two's-complement signed mode
- overflow saturation
- a leading-zero blank mask

It sits between the datapath result register and the 7-segment/LCD digit drivers. It converts one bit per clock.

---
 rtl/binary_to_bcd_seq.sv | 118 +++++++++++
 1 files changed

// File: rtl/binary_to_bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter, one input bit per clock.
// Adds a start/busy/done handshake, a two's-complement mode, overflow saturation and a leading-zero blank mask.
module binary_to_bcd_seq #(
    parameter int WIDTH  = 36,
    parameter int DIGITS = 9
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  start,
    input  logic                  is_signed,
    input  logic [WIDTH-1:0]      data,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  negative,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} ^ DIGITS'(1);
    localparam logic [BW-1:0]     ALL_NINES = {DIGITS{4'h9}};

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    work_bcd;
    logic [WIDTH-1:0] work_mag;
    logic             work_neg;
    logic             work_ovf;

    logic [BW-1:0]     adj_bcd;
    logic [WIDTH-1:0]  load_mag;
    logic              load_neg;
    logic [BW-1:0]     res_bcd;
    logic [DIGITS-1:0] res_blank;

    assign busy = (state != IDLE);

    // Negating the most negative value wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
    assign load_neg = is_signed & data[WIDTH-1];
    assign load_mag = load_neg ? (~data + WIDTH'(1)) : data;

    // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        adj_bcd = work_bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (work_bcd[4*k +: 4] >= 4'd5)
                adj_bcd[4*k +: 4] = work_bcd[4*k +: 4] + 4'd3;
        end
    end

    // Blank bit k marks digit k as a leading zero; digit 0 is always shown.
    always_comb begin
        logic all_zero;
        res_bcd   = work_ovf ? ALL_NINES : work_bcd;
        res_blank = '0;
        all_zero  = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            all_zero     = all_zero & (res_bcd[4*k +: 4] == 4'd0);
            res_blank[k] = all_zero;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            work_bcd <= '0;
            work_mag <= '0;
            work_neg <= 1'b0;
            work_ovf <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            negative <= 1'b0;
            overflow <= 1'b0;
            blank    <= BLANK_RST;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        work_mag <= load_mag;
                        work_neg <= load_neg;
                        work_bcd <= '0;
                        work_ovf <= 1'b0;
                        cnt      <= CW'(WIDTH);
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // A carry out of the top digit means the value no longer fits in DIGITS digits.
                    {work_bcd, work_mag} <= {adj_bcd[BW-2:0], work_mag, 1'b0};
                    work_ovf             <= work_ovf | adj_bcd[BW-1];
                    cnt                  <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= FINISH;
                end
                FINISH: begin
                    bcd      <= res_bcd;
                    blank    <= res_blank;
                    negative <= work_neg;
                    overflow <= work_ovf;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
